// File: rtl/hub75_bcm_scheduler.sv
// HUB75 scan scheduler: bit-plane shifting, latching, binary-weighted OE
// display time, and frame-boundary framebuffer swap arbitration.
module hub75_bcm_scheduler #(
  parameter int unsigned COLS     = 64,
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned PLANES   = 3,
  parameter int unsigned BASE_OE  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     fb_rd_en,
  output logic                     fb_buf,
  output logic [ROW_BITS-1:0]      fb_row,
  output logic [$clog2(COLS)-1:0]  fb_col,
  input  logic [3*PLANES-1:0]      pix_top,
  input  logic [3*PLANES-1:0]      pix_bot,
  output logic                     R0,
  output logic                     G0,
  output logic                     B0,
  output logic                     R1,
  output logic                     G1,
  output logic                     B1,
  output logic                     SCLK,
  output logic                     LAT,
  output logic                     OE,
  output logic                     A,
  output logic                     B,
  output logic                     C,
  output logic                     D,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic                     frame_done
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned PL_W  = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int unsigned CNT_W = $clog2(BASE_OE * (1 << PLANES));
  localparam int unsigned PIX_W = 3 * PLANES;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    TAIL    = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PL_W-1:0]     plane_q, plane_d;
  logic [ROW_BITS-1:0] row_q, row_d;

  logic                fb_rd_en_q, fb_rd_en_d;
  logic                fb_buf_q, fb_buf_d;
  logic [ROW_BITS-1:0] fb_row_q, fb_row_d;
  logic [COL_W-1:0]    fb_col_q, fb_col_d;
  logic [5:0]          rgb_q, rgb_d;
  logic                sclk_q, sclk_d;
  logic                lat_q, lat_d;
  logic                oe_q, oe_d;
  logic [3:0]          addr_q, addr_d;
  logic                swap_ack_q, swap_ack_d;
  logic                frame_done_q, frame_done_d;

  logic [CNT_W-1:0]    disp_last;
  logic                last_disp, last_plane, last_row, frame_end;
  logic [PIX_W-1:0]    top_sh, bot_sh;

  // Plane timing and frame-boundary decode
  always_comb begin
    disp_last  = CNT_W'((BASE_OE << plane_q) - 1);
    last_disp  = (state_q == DISPLAY) && (cnt_q == disp_last);
    last_plane = (plane_q == PL_W'(PLANES - 1));
    last_row   = (row_q == {ROW_BITS{1'b1}});
    frame_end  = last_disp && last_plane && last_row;
    top_sh     = pix_top >> plane_q;
    bot_sh     = pix_bot >> plane_q;
  end

  // Next-state, counters and next output values; outputs trail the state by one cycle
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    plane_d      = plane_q;
    row_d        = row_q;
    fb_buf_d     = fb_buf_q;
    rgb_d        = rgb_q;
    addr_d       = addr_q;
    fb_rd_en_d   = (state_q == SHIFT) && !phase_q;
    fb_row_d     = row_q;
    fb_col_d     = col_q;
    sclk_d       = ((state_q == SHIFT) && !phase_q && (col_q != '0)) || (state_q == TAIL);
    lat_d        = (state_q == LATCH);
    oe_d         = (state_q != DISPLAY);
    frame_done_d = frame_end;
    swap_ack_d   = frame_end && swap_req;

    // Pixel data read for the previous column arrives as the shift clock rises for it
    if (sclk_d) begin
      rgb_d = {top_sh[2*PLANES], top_sh[PLANES], top_sh[0],
               bot_sh[2*PLANES], bot_sh[PLANES], bot_sh[0]};
    end
    if (state_q == LATCH) begin
      addr_d = 4'(row_q);
    end
    if (frame_end && swap_req) begin
      fb_buf_d = ~fb_buf_q;
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHIFT;
          col_d   = '0;
          phase_d = 1'b0;
        end
      end
      SHIFT: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          col_d = col_q + COL_W'(1);
          if (col_q == COL_W'(COLS - 1)) begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        state_d = LATCH;
      end
      LATCH: begin
        state_d = DISPLAY;
        cnt_d   = '0;
      end
      DISPLAY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_disp) begin
          cnt_d = '0;
          if (last_plane) begin
            plane_d = '0;
            row_d   = row_q + ROW_BITS'(1);
          end else begin
            plane_d = plane_q + PL_W'(1);
          end
          state_d = (frame_end && !en) ? IDLE : SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset blanks the panel immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      phase_q      <= 1'b0;
      cnt_q        <= '0;
      plane_q      <= '0;
      row_q        <= '0;
      fb_rd_en_q   <= 1'b0;
      fb_buf_q     <= 1'b0;
      fb_row_q     <= '0;
      fb_col_q     <= '0;
      rgb_q        <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_q         <= 1'b1;
      addr_q       <= '0;
      swap_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      plane_q      <= plane_d;
      row_q        <= row_d;
      fb_rd_en_q   <= fb_rd_en_d;
      fb_buf_q     <= fb_buf_d;
      fb_row_q     <= fb_row_d;
      fb_col_q     <= fb_col_d;
      rgb_q        <= rgb_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_q         <= oe_d;
      addr_q       <= addr_d;
      swap_ack_q   <= swap_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb_rd_en   = fb_rd_en_q;
  assign fb_buf     = fb_buf_q;
  assign fb_row     = fb_row_q;
  assign fb_col     = fb_col_q;
  assign {R0, G0, B0, R1, G1, B1} = rgb_q;
  assign SCLK       = sclk_q;
  assign LAT        = lat_q;
  assign OE         = oe_q;
  assign {D, C, B, A} = addr_q;
  assign swap_ack   = swap_ack_q;
  assign frame_done = frame_done_q;

endmodule
